// File: rtl/decode_execute_pipe.sv
// Decode-to-execute pipeline register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. M drives the outputs; S catches the bundle accepted during a stall.
module decode_execute_pipe #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [REG_W-1:0]  dst_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [REG_W-1:0]  dst_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    localparam int BW = 2*DATA_W + IMM_W + 3*REG_W + CTRL_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t          state, state_next;
    logic [BW-1:0]   m_q, s_q, bundle_in;
    logic            accept, drain;
    logic            load_m_in, load_m_skid, load_s;

    assign bundle_in = {rd1_in, rd2_in, imm_in, dst_in, src1_in, src2_in, ctrl_in};
    assign {rd1_out, rd2_out, imm_out, dst_out, src1_out, src2_out, ctrl_out} = m_q;

    // Both handshake outputs decode straight from the state register, so
    // in_ready never depends combinationally on out_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_next  = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_m_in  = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_s     = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next  = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Flush is treated exactly like reset: contents squashed to a NOP bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            state <= state_next;
            if (load_m_in)
                m_q <= bundle_in;
            else if (load_m_skid)
                m_q <= s_q;
            if (load_s)
                s_q <= bundle_in;
        end
    end

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe: default-width instance plus a wide instance.
module tb_decode_execute_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] rd1_in, rd2_in, imm_in, rd1_out, rd2_out, imm_out;
    logic [3:0]  dst_in, src1_in, src2_in, dst_out, src1_out, src2_out;
    logic [7:0]  ctrl_in, ctrl_out;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_rd1_in, w_rd2_in, w_rd1_out, w_rd2_out;
    logic [15:0] w_imm_in, w_imm_out;
    logic [4:0]  w_dst_in, w_src1_in, w_src2_in, w_dst_out, w_src1_out, w_src2_out;
    logic [11:0] w_ctrl_in, w_ctrl_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_execute_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .dst_in(dst_in), .src1_in(src1_in), .src2_in(src2_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .dst_out(dst_out), .src1_out(src1_out), .src2_out(src2_out), .ctrl_out(ctrl_out)
    );

    decode_execute_pipe #(.DATA_W(32), .IMM_W(16), .REG_W(5), .CTRL_W(12)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .rd1_in(w_rd1_in), .rd2_in(w_rd2_in), .imm_in(w_imm_in),
        .dst_in(w_dst_in), .src1_in(w_src1_in), .src2_in(w_src2_in), .ctrl_in(w_ctrl_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .rd1_out(w_rd1_out), .rd2_out(w_rd2_out), .imm_out(w_imm_out),
        .dst_out(w_dst_out), .src1_out(w_src1_out), .src2_out(w_src2_out), .ctrl_out(w_ctrl_out)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] rd1, input logic [3:0] dst,
                         input logic [7:0] ctrl);
        in_valid = v;
        rd1_in   = rd1;
        rd2_in   = rd1 ^ 16'h5A5A;
        imm_in   = ~rd1;
        dst_in   = dst;
        src1_in  = dst + 4'd1;
        src2_in  = dst + 4'd2;
        ctrl_in  = ctrl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 4'hF, 8'hFF);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if ({rd1_out, rd2_out, imm_out, dst_out, src1_out, src2_out, ctrl_out} !== '0) begin
            errors++; $display("FAIL reset_payload got rd1=%h ctrl=%h dst=%h exp 0", rd1_out, ctrl_out, dst_out); end
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, 4'h6, 8'h01);
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid got %b exp 1", out_valid); end
        checks++; if (rd1_out !== 16'h1234) begin errors++; $display("FAIL first_accept_rd1 got %h exp 1234", rd1_out); end
        checks++; if (imm_out !== 16'hEDCB) begin errors++; $display("FAIL first_accept_imm got %h exp edcb", imm_out); end
        drive(1'b0, 16'h0, 4'h0, 8'h0);
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_to_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [15:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp = 16'(i);
            drive(1'b1, exp, 4'(i), 8'h10);
            step();
            checks++; if (out_valid !== 1'b1 || rd1_out !== exp) begin
                errors++; $display("FAIL stream_rd1[%0d] got v=%b %h exp v=1 %h", i, out_valid, rd1_out, exp); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
        end
        drive(1'b0, 16'h0, 4'h0, 8'h0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 16'hA, 4'd3, 8'h21);
        step();
        checks++; if (dst_out !== 4'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_A got dst=%0d rdy=%b exp dst=3 rdy=1", dst_out, in_ready); end
        drive(1'b1, 16'hB, 4'd5, 8'h22);
        step();
        checks++; if (in_ready !== 1'b0 || dst_out !== 4'd3) begin
            errors++; $display("FAIL bp_B got rdy=%b dst=%0d exp rdy=0 dst=3", in_ready, dst_out); end
        drive(1'b1, 16'hC, 4'd7, 8'h23);
        step();
        checks++; if (in_ready !== 1'b0 || dst_out !== 4'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold got rdy=%b dst=%0d v=%b exp 0 3 1", in_ready, dst_out, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (dst_out !== 4'd5 || rd1_out !== 16'hB || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_seq5 got dst=%0d rd1=%h rdy=%b exp 5 b 1", dst_out, rd1_out, in_ready); end
        step();
        checks++; if (dst_out !== 4'd7 || ctrl_out !== 8'h23 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_seq7 got dst=%0d ctrl=%h v=%b exp 7 23 1", dst_out, ctrl_out, out_valid); end
        drive(1'b0, 16'h0, 4'h0, 8'h0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got v=%b exp 0", out_valid); end
    endtask

    task automatic fill_full();
        out_ready = 1'b0;
        drive(1'b1, 16'h0111, 4'd1, 8'h31);
        step();
        drive(1'b1, 16'h0222, 4'd2, 8'h32);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got rdy=%b exp 0", in_ready); end
    endtask

    task automatic test_flush();
        fill_full();
        drive(1'b1, 16'h0333, 4'd9, 8'h33);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || ctrl_out !== 8'h00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b ctrl=%h rdy=%b exp 0 00 1", out_valid, ctrl_out, in_ready); end
        checks++; if (rd1_out !== 16'h0 || dst_out !== 4'h0) begin
            errors++; $display("FAIL flush_payload got rd1=%h dst=%h exp 0 0", rd1_out, dst_out); end
        drive(1'b0, 16'h0, 4'h0, 8'h0);
        out_ready = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_emerges got v=%b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        fill_full();
        drive(1'b0, 16'h0, 4'h0, 8'h0);
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_hs got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        checks++; if ({rd1_out, rd2_out, imm_out, dst_out, src1_out, src2_out, ctrl_out} !== '0) begin
            errors++; $display("FAIL rstmid_payload got rd1=%h dst=%h ctrl=%h exp 0", rd1_out, dst_out, ctrl_out); end
    endtask

    task automatic test_param_sweep();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_rd1_in    = 32'h8000_0001;
        w_rd2_in    = 32'hDEADBEEF;
        w_imm_in    = 16'hFFFE;
        w_dst_in    = 5'd17;
        w_src1_in   = 5'd16;
        w_src2_in   = 5'd31;
        w_ctrl_in   = 12'hABC;
        step();
        w_in_valid  = 1'b0;
        checks++; if (w_out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid got %b exp 1", w_out_valid); end
        checks++; if (w_rd2_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_rd2 got %h exp deadbeef", w_rd2_out); end
        checks++; if (w_rd1_out !== 32'h8000_0001) begin errors++; $display("FAIL wide_rd1 got %h exp 80000001", w_rd1_out); end
        checks++; if (w_src2_out !== 5'd31 || w_dst_out !== 5'd17 || w_src1_out !== 5'd16) begin
            errors++; $display("FAIL wide_regs got src2=%0d dst=%0d src1=%0d exp 31 17 16", w_src2_out, w_dst_out, w_src1_out); end
        checks++; if (w_ctrl_out !== 12'hABC || w_imm_out !== 16'hFFFE) begin
            errors++; $display("FAIL wide_ctrl_imm got ctrl=%h imm=%h exp abc fffe", w_ctrl_out, w_imm_out); end
        step();
        checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wide_drain got %b exp 0", w_out_valid); end
    endtask

    initial begin
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        w_rd1_in = '0; w_rd2_in = '0; w_imm_in = '0;
        w_dst_in = '0; w_src1_in = '0; w_src2_in = '0; w_ctrl_in = '0;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
